word_search_ctrl: RTL and testbench

//  Sequences one best-word search: clears the max-score register (regf), walks word indices
//  1..num_words through the word scoring engine over a req/valid handshake, and forwards

---
 rtl/wsc_pkg.sv | 27 ++
 rtl/word_search_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_word_search_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wsc_pkg.sv
`default_nettype none
//==============================================================================
// Package     : wsc_pkg
// Description : Shared definitions for the best-word search controller, the
//               max-score register file and the word scoring engine.
// Revision    : 1.0 - initial release
//==============================================================================
package wsc_pkg;

    // Default widths shared by the controller, regf and scorer
    localparam int WSC_SCORE_W = 21;
    localparam int WSC_IDX_W   = 6;
    localparam int WSC_TO_W    = 8;

    // Search sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        REQ    = 3'd2,
        WAIT   = 3'd3,
        UPDATE = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } wsc_state_e;

endpackage : wsc_pkg
`default_nettype wire

// File: rtl/word_search_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : word_search_ctrl
// Description : Sequences one best-word search. Clears regf, walks word
//               indices 1..num_words through the scorer over a req/valid
//               handshake and forwards each returned score to regf with a
//               one-cycle enable. Words whose score never arrives are skipped
//               after a bounded wait and flagged in a sticky error bit.
// Revision    : 1.0 - initial release
//==============================================================================
module word_search_ctrl
    import wsc_pkg::*;
#(
    parameter int SCORE_W = WSC_SCORE_W,
    parameter int IDX_W   = WSC_IDX_W,
    parameter int TO_W    = WSC_TO_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [IDX_W-1:0]   num_words,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic               score_req,
    output logic [IDX_W-1:0]   score_word,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score_in,
    output logic               rf_clear,
    output logic               rf_en,
    output logic [SCORE_W-1:0] rf_fscore,
    output logic [IDX_W-1:0]   rf_word_index
);

    // Last count value of the wait counter; reaching it ends the wait
    localparam logic [TO_W-1:0] TO_MAX = '1;

    wsc_state_e         state, state_nxt;
    logic [IDX_W-1:0]   nw, nw_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [TO_W-1:0]    cnt, cnt_nxt;
    logic [TO_W-1:0]    cnt_inc;
    logic               busy_nxt;
    logic               done_nxt;
    logic               terr_nxt;
    logic               req_nxt;
    logic [IDX_W-1:0]   word_nxt;
    logic               clr_nxt;
    logic               en_nxt;
    logic [SCORE_W-1:0] fscore_nxt;
    logic [IDX_W-1:0]   widx_nxt;

    // State and output registers; every output is driven straight from a flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            nw            <= '0;
            idx           <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            score_req     <= 1'b0;
            score_word    <= '0;
            rf_clear      <= 1'b0;
            rf_en         <= 1'b0;
            rf_fscore     <= '0;
            rf_word_index <= '0;
        end else begin
            state         <= state_nxt;
            nw            <= nw_nxt;
            idx           <= idx_nxt;
            cnt           <= cnt_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            timeout_err   <= terr_nxt;
            score_req     <= req_nxt;
            score_word    <= word_nxt;
            rf_clear      <= clr_nxt;
            rf_en         <= en_nxt;
            rf_fscore     <= fscore_nxt;
            rf_word_index <= widx_nxt;
        end
    end

    // Next-state and next-output decode. The clear, request and enable pulses
    // are registered on entry to CLEAR/REQ/UPDATE so they are high exactly
    // while the sequencer sits in that state; done is registered on the exit
    // from DONE, together with busy dropping.
    always_comb begin
        state_nxt  = state;
        nw_nxt     = nw;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        terr_nxt   = timeout_err;
        req_nxt    = 1'b0;
        word_nxt   = score_word;
        clr_nxt    = 1'b0;
        en_nxt     = 1'b0;
        fscore_nxt = rf_fscore;
        widx_nxt   = rf_word_index;
        cnt_inc    = cnt + 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    nw_nxt    = num_words;
                    terr_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    clr_nxt   = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                idx_nxt = IDX_W'(1);
                if (nw == '0) begin
                    state_nxt = DONE;
                end else begin
                    req_nxt   = 1'b1;
                    word_nxt  = IDX_W'(1);
                    state_nxt = REQ;
                end
            end
            REQ: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A score arriving on the expiry cycle still counts
                if (score_valid) begin
                    fscore_nxt = score_in;
                    widx_nxt   = idx;
                    en_nxt     = 1'b1;
                    state_nxt  = UPDATE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == TO_MAX) begin
                        terr_nxt  = 1'b1;
                        state_nxt = NEXT;
                    end
                end
            end
            UPDATE: begin
                state_nxt = NEXT;
            end
            NEXT: begin
                if (idx == nw) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    req_nxt   = 1'b1;
                    word_nxt  = idx + 1'b1;
                    state_nxt = REQ;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides everything, including a start seen in IDLE
        if (abort) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
            req_nxt   = 1'b0;
            clr_nxt   = 1'b0;
            en_nxt    = 1'b0;
        end
    end

endmodule : word_search_ctrl
`default_nettype wire

// File: tb/tb_word_search_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_word_search_ctrl
// Description : Bench for word_search_ctrl with a behavioural regf and scorer.
//               A timeline model predicts every output for every cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_word_search_ctrl;

    localparam int SW      = 21;
    localparam int IW      = 6;
    localparam int TW      = 8;
    localparam int NCYC    = 2048;
    localparam int TO_WAIT = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [IW-1:0] num_words = '0;
    logic          busy, done, timeout_err, score_req, rf_clear, rf_en;
    logic [IW-1:0] score_word, rf_word_index;
    logic          score_valid = 1'b0;
    logic [SW-1:0] score_in = '0;
    logic [SW-1:0] rf_fscore;

    word_search_ctrl #(.SCORE_W(SW), .IDX_W(IW), .TO_W(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .num_words(num_words), .busy(busy), .done(done),
        .timeout_err(timeout_err), .score_req(score_req),
        .score_word(score_word), .score_valid(score_valid),
        .score_in(score_in), .rf_clear(rf_clear), .rf_en(rf_en),
        .rf_fscore(rf_fscore), .rf_word_index(rf_word_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad   = 0;

    // Expected per-cycle outputs
    bit exp_clear[NCYC], exp_req[NCYC], exp_en[NCYC];
    bit exp_done[NCYC], exp_busy[NCYC], exp_terr[NCYC];
    int exp_word[NCYC], exp_score[NCYC], exp_widx[NCYC];
    int plan_end = 0;
    int s_last = 0;

    // Scorer behaviour per word: latency in cycles after req (0 = never) and score
    int lat_tab[64];
    int score_tab[64];
    int stray_a = -1, stray_b = -1;

    // Observation counters
    int n_en = 0, n_clr = 0, n_req = 0, n_done = 0, done_cyc = -1;

    // Behavioural regf: keeps the first word holding the strictly highest score
    int rf_max = 0, rf_result = 0;

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predict one search started (start sampled) at the edge ending cycle s
    task automatic plan_search(input int s, input int nw);
        int t;
        for (int c = s + 1; c < NCYC; c++) exp_terr[c] = 1'b0;
        exp_clear[s+1] = 1'b1;
        t = s + 2;
        for (int w = 1; w <= nw; w++) begin
            exp_req[t]  = 1'b1;
            exp_word[t] = w;
            if (lat_tab[w] > 0) begin
                exp_en[t+lat_tab[w]+1]    = 1'b1;
                exp_score[t+lat_tab[w]+1] = score_tab[w];
                exp_widx[t+lat_tab[w]+1]  = w;
                t = t + 3 + lat_tab[w];
            end else begin
                for (int c = t + TO_WAIT + 1; c < NCYC; c++) exp_terr[c] = 1'b1;
                t = t + TO_WAIT + 2;
            end
        end
        for (int c = s + 1; c <= t; c++) exp_busy[c] = 1'b1;
        exp_done[t+1] = 1'b1;
        plan_end = t + 1;
    endtask

    // Remove everything predicted from cycle f on (abort or reset)
    task automatic kill_from(input int f, input bit keep_terr);
        bit tv;
        tv = keep_terr ? exp_terr[f-1] : 1'b0;
        for (int c = f; c < NCYC; c++) begin
            exp_clear[c] = 1'b0; exp_req[c] = 1'b0; exp_en[c] = 1'b0;
            exp_done[c]  = 1'b0; exp_busy[c] = 1'b0; exp_terr[c] = tv;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_start(input int nw);
        @(posedge clk); #1;
        start = 1'b1;
        num_words = IW'(nw);
        s_last = cyc;
        plan_search(cyc, nw);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clr_counts();
        n_en = 0; n_clr = 0; n_req = 0; n_done = 0; done_cyc = -1;
    endtask

    task automatic set_word(input int w, input int lat, input int sc);
        lat_tab[w] = lat;
        score_tab[w] = sc;
    endtask

    // Regf model
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_max = 0; rf_result = 0;
        end else if (rf_clear) begin
            rf_max = 0; rf_result = 0;
        end else if (rf_en && int'(rf_fscore) > rf_max) begin
            rf_max = int'(rf_fscore);
            rf_result = int'(rf_word_index) - 1;
        end
    end

    // Scorer model: answers each request after its word's latency
    int pend_left = 0, pend_word = 0;
    always begin
        bit ab;
        @(posedge clk);
        ab = abort;
        #1;
        score_valid = 1'b0;
        score_in = SW'(21'h0ABCD);
        if (ab || !reset) pend_left = 0;
        if (pend_left > 0) begin
            if (pend_left == 1) begin
                score_valid = 1'b1;
                score_in = SW'(score_tab[pend_word]);
            end
            pend_left = pend_left - 1;
        end
        if (cyc == stray_a || cyc == stray_b) begin
            score_valid = 1'b1;
            score_in = SW'(1000000);
        end
        if (score_req && reset && lat_tab[int'(score_word)] > 0) begin
            pend_left = lat_tab[int'(score_word)];
            pend_word = int'(score_word);
        end
    end

    // Compare process: every cycle against the timeline model
    always @(negedge clk) begin
        if (cyc < NCYC) begin
            check("busy", int'(busy), int'(exp_busy[cyc]));
            check("done", int'(done), int'(exp_done[cyc]));
            check("timeout_err", int'(timeout_err), int'(exp_terr[cyc]));
            check("score_req", int'(score_req), int'(exp_req[cyc]));
            check("rf_clear", int'(rf_clear), int'(exp_clear[cyc]));
            check("rf_en", int'(rf_en), int'(exp_en[cyc]));
            if (exp_req[cyc]) check("score_word", int'(score_word), exp_word[cyc]);
            if (exp_en[cyc]) begin
                check("rf_fscore", int'(rf_fscore), exp_score[cyc]);
                check("rf_word_index", int'(rf_word_index), exp_widx[cyc]);
            end
        end
        if (rf_en) n_en = n_en + 1;
        if (rf_clear) n_clr = n_clr + 1;
        if (score_req) n_req = n_req + 1;
        if (done) begin
            n_done = n_done + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        int s;
        for (int w = 0; w < 64; w++) begin
            lat_tab[w] = 2;
            score_tab[w] = w;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #4;
        check("rst_busy", int'(busy), 0);
        check("rst_score_word", int'(score_word), 0);
        check("rst_rf_fscore", int'(rf_fscore), 0);
        check("rst_rf_word_index", int'(rf_word_index), 0);
        #0 reset = 1'b1;
        wait_until(cyc + 2);

        // 1: four words, scores 5,9,3,9, answer 2 cycles after req
        set_word(1, 2, 5); set_word(2, 2, 9); set_word(3, 2, 3); set_word(4, 2, 9);
        clr_counts();
        do_start(4);
        s = s_last;
        wait_until(plan_end + 2);
        check("t1_clears", n_clr, 1);
        check("t1_enables", n_en, 4);
        check("t1_reqs", n_req, 4);
        check("t1_dones", n_done, 1);
        check("t1_done_cycle", done_cyc - s, 23);
        check("t1_result", rf_result, 1);

        // 2: zero words
        clr_counts();
        do_start(0);
        s = s_last;
        wait_until(plan_end + 2);
        check("t2_done_cycle", done_cyc - s, 3);
        check("t2_reqs", n_req, 0);
        check("t2_clears", n_clr, 1);
        check("t2_result", rf_result, 0);

        // 3: word 2 never answered
        set_word(1, 2, 4); set_word(2, 0, 50); set_word(3, 2, 7);
        clr_counts();
        do_start(3);
        s = s_last;
        wait_until(plan_end + 2);
        check("t3_done_cycle", done_cyc - s, 270);
        check("t3_timeout_err", int'(timeout_err), 1);
        check("t3_enables", n_en, 2);
        check("t3_dones", n_done, 1);
        check("t3_result", rf_result, 2);

        // 4: abort in WAIT of word 2, then start+abort in IDLE, then restart
        set_word(1, 2, 4); set_word(2, 20, 30);
        clr_counts();
        do_start(5);
        s = s_last;
        wait_until(s + 12);
        abort = 1'b1;
        kill_from(s + 13, 1'b1);
        @(posedge clk); #1;
        abort = 1'b0;
        check("t4_terr_cleared", int'(timeout_err), 0);
        wait_until(cyc + 3);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        wait_until(cyc + 4);
        check("t4_no_done", n_done, 0);
        check("t4_idle_busy", int'(busy), 0);
        set_word(1, 2, 8); set_word(2, 2, 2);
        clr_counts();
        do_start(2);
        wait_until(plan_end + 2);
        check("t4_restart_dones", n_done, 1);
        check("t4_restart_result", rf_result, 0);

        // 5: stray valid in IDLE and REQ, start pulses while busy
        set_word(1, 2, 1); set_word(2, 2, 6); set_word(3, 2, 6);
        stray_a = cyc + 2;
        wait_until(cyc + 4);
        clr_counts();
        do_start(3);
        s = s_last;
        stray_b = s + 7;
        wait_until(s + 4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_until(s + 10);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_until(plan_end + 2);
        check("t5_done_cycle", done_cyc - s, 18);
        check("t5_enables", n_en, 3);
        check("t5_reqs", n_req, 3);
        check("t5_result", rf_result, 1);

        // 6: asynchronous reset during word 3
        for (int w = 1; w <= 6; w++) set_word(w, 2, 10 + w);
        clr_counts();
        do_start(6);
        s = s_last;
        wait_until(s + 13);
        kill_from(s + 13, 1'b0);
        #2 reset = 1'b0;
        #2;
        check("t6_busy", int'(busy), 0);
        check("t6_score_word", int'(score_word), 0);
        check("t6_rf_fscore", int'(rf_fscore), 0);
        check("t6_rf_word_index", int'(rf_word_index), 0);
        wait_until(s + 15);
        #2 reset = 1'b1;
        set_word(1, 2, 3); set_word(2, 2, 5);
        clr_counts();
        do_start(2);
        wait_until(plan_end + 2);
        check("t6_fresh_dones", n_done, 1);
        check("t6_fresh_result", rf_result, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_word_search_ctrl
`default_nettype wire
